// File: rtl/seq_chunk_cmp_if.sv
// rtl/seq_chunk_cmp_if.sv - request/response bundle for the chunked sequential comparator
// master drives the request side, slave returns status and registered flags.
interface seq_chunk_cmp_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             result;
   logic             eq;
   logic             lt_s;
   logic             lt_u;

   modport master (
      output start, op, a, b,
      input  busy, done, result, eq, lt_s, lt_u
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result, eq, lt_s, lt_u
   );
endinterface

// File: rtl/seq_chunk_cmp.sv
// rtl/seq_chunk_cmp.sv - multi-cycle comparator scanning CHUNK bits per cycle from the MSB chunk
// Stops at the first differing chunk; only the MSB chunk is compared as signed.
module seq_chunk_cmp #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic            clk,
   input  logic            reset,
   seq_chunk_cmp_if.slave  bus
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [2:0]       op_q;
   logic [IW-1:0]    idx_q;
   logic             busy_q, done_q, result_q, eq_q, lt_s_q, lt_u_q;

   logic [CHUNK-1:0] ca, cb;
   logic             chunk_ne, last_chunk;
   logic             eq_d, lt_s_d, lt_u_d, result_d;

   always_comb begin
      ca         = a_q[int'(idx_q) * CHUNK +: CHUNK];
      cb         = b_q[int'(idx_q) * CHUNK +: CHUNK];
      chunk_ne   = (ca != cb);
      last_chunk = (idx_q == '0);
      eq_d       = 1'b1;
      lt_u_d     = 1'b0;
      lt_s_d     = 1'b0;
      if (chunk_ne) begin
         eq_d   = 1'b0;
         lt_u_d = (ca < cb);
         // The sign bit lives only in the top chunk; below it magnitude order is unsigned.
         lt_s_d = (idx_q == IW'(NCHUNK - 1)) ? ($signed(ca) < $signed(cb)) : (ca < cb);
      end
      case (op_q)
         3'd0:    result_d = eq_d;
         3'd1:    result_d = !eq_d;
         3'd2:    result_d = lt_s_d;
         3'd3:    result_d = !lt_s_d;
         3'd4:    result_d = lt_u_d;
         3'd5:    result_d = !lt_u_d;
         3'd6:    result_d = lt_s_d | eq_d;
         default: result_d = !(lt_s_d | eq_d);
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         idx_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= 1'b0;
         eq_q     <= 1'b0;
         lt_s_q   <= 1'b0;
         lt_u_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  a_q     <= bus.a;
                  b_q     <= bus.b;
                  op_q    <= bus.op;
                  idx_q   <= IW'(NCHUNK - 1);
                  busy_q  <= 1'b1;
                  state_q <= S_SCAN;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            S_SCAN: begin
               if (chunk_ne || last_chunk) begin
                  eq_q     <= eq_d;
                  lt_s_q   <= lt_s_d;
                  lt_u_q   <= lt_u_d;
                  result_q <= result_d;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= S_DONE;
               end else begin
                  idx_q <= idx_q - IW'(1);
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.eq     = eq_q;
   assign bus.lt_s   = lt_s_q;
   assign bus.lt_u   = lt_u_q;
endmodule

// File: tb/tb_seq_chunk_cmp.sv
// tb/tb_seq_chunk_cmp.sv - directed and model-checked bench for seq_chunk_cmp at three geometries
// Instance 0: 32/8, instance 1: 64/16, instance 2: 32/32.
module tb_seq_chunk_cmp;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   int          tests = 0;
   int          fails = 0;
   int          cur   = 0;
   logic        start_v = 1'b0;
   logic [63:0] a_v = '0, b_v = '0;
   logic [2:0]  op_v = '0;

   seq_chunk_cmp_if #(.WIDTH(32)) if0 ();
   seq_chunk_cmp_if #(.WIDTH(64)) if1 ();
   seq_chunk_cmp_if #(.WIDTH(32)) if2 ();

   seq_chunk_cmp #(.WIDTH(32), .CHUNK(8))  u0 (.clk(clk), .reset(rst_n), .bus(if0));
   seq_chunk_cmp #(.WIDTH(64), .CHUNK(16)) u1 (.clk(clk), .reset(rst_n), .bus(if1));
   seq_chunk_cmp #(.WIDTH(32), .CHUNK(32)) u2 (.clk(clk), .reset(rst_n), .bus(if2));

   assign if0.start = start_v && (cur == 0);
   assign if1.start = start_v && (cur == 1);
   assign if2.start = start_v && (cur == 2);
   assign if0.a = a_v[31:0];  assign if0.b = b_v[31:0];  assign if0.op = op_v;
   assign if1.a = a_v;        assign if1.b = b_v;        assign if1.op = op_v;
   assign if2.a = a_v[31:0];  assign if2.b = b_v[31:0];  assign if2.op = op_v;

   logic m_busy, m_done;
   logic [3:0] m_flags;
   always_comb begin
      m_busy  = if0.busy;
      m_done  = if0.done;
      m_flags = {if0.result, if0.eq, if0.lt_s, if0.lt_u};
      if (cur == 1) begin
         m_busy  = if1.busy;
         m_done  = if1.done;
         m_flags = {if1.result, if1.eq, if1.lt_s, if1.lt_u};
      end else if (cur == 2) begin
         m_busy  = if2.busy;
         m_done  = if2.done;
         m_flags = {if2.result, if2.eq, if2.lt_s, if2.lt_u};
      end
   end

   task automatic wait_done(inout int lat);
      while (!m_done && lat < 200) begin
         @(posedge clk); lat++;
         @(negedge clk);
      end
      if (!m_done) begin
         tests++; fails++;
         $display("FAIL timeout inst=%0d no done after %0d edges, required done=1", cur, lat);
      end
   endtask

   task automatic run(input int which, input logic [63:0] a, input logic [63:0] b,
                      input logic [2:0] op, output int lat);
      @(negedge clk);
      cur = which; a_v = a; b_v = b; op_v = op; start_v = 1'b1;
      @(posedge clk); lat = 1;
      @(negedge clk); start_v = 1'b0;
      wait_done(lat);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      for (int i = 0; i < 3; i++) begin
         cur = i; #1;
         tests++;
         if ({m_busy, m_done, m_flags} !== 6'b0) begin
            fails++;
            $display("FAIL reset inst=%0d got %b required 000000", i, {m_busy, m_done, m_flags});
         end
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_equal();
      int lat;
      run(0, 64'h12345678, 64'h12345678, 3'd0, lat);
      tests++;
      if (lat !== 5 || m_flags !== 4'b1100 || m_busy !== 1'b0) begin
         fails++;
         $display("FAIL equal got lat=%0d flags=%b busy=%b required lat=5 flags=1100 busy=0", lat, m_flags, m_busy);
      end
      @(negedge clk);
      tests++;
      if (m_done !== 1'b0 || m_flags !== 4'b1100) begin
         fails++;
         $display("FAIL done_pulse got done=%b flags=%b required done=0 flags=1100", m_done, m_flags);
      end
   endtask

   task automatic test_msb_signed();
      int lat;
      run(0, 64'h80000000, 64'h1, 3'd2, lat);
      tests++;
      if (lat !== 2 || m_flags !== 4'b1010) begin
         fails++;
         $display("FAIL msb_lt got lat=%0d flags=%b required lat=2 flags=1010", lat, m_flags);
      end
      run(0, 64'h80000000, 64'h1, 3'd5, lat);
      tests++;
      if (lat !== 2 || m_flags !== 4'b1010) begin
         fails++;
         $display("FAIL msb_geu got lat=%0d flags=%b required lat=2 flags=1010", lat, m_flags);
      end
   endtask

   task automatic test_low_chunk();
      int lat;
      run(0, 64'h000000FF, 64'h00000100, 3'd4, lat);
      tests++;
      if (lat !== 4 || m_flags !== 4'b1011) begin
         fails++;
         $display("FAIL low_ltu got lat=%0d flags=%b required lat=4 flags=1011", lat, m_flags);
      end
      run(0, 64'h000000FF, 64'h00000100, 3'd7, lat);
      tests++;
      if (lat !== 4 || m_flags !== 4'b0011) begin
         fails++;
         $display("FAIL low_gt got lat=%0d flags=%b required lat=4 flags=0011", lat, m_flags);
      end
   endtask

   task automatic test_ignore_busy();
      int lat;
      @(negedge clk);
      cur = 0; a_v = 64'h12345678; b_v = 64'h12345678; op_v = 3'd0; start_v = 1'b1;
      @(posedge clk); lat = 1;
      @(negedge clk); a_v = 64'h0; b_v = 64'h1; op_v = 3'd1;
      @(posedge clk); lat++;
      @(negedge clk); start_v = 1'b0;
      wait_done(lat);
      tests++;
      if (lat !== 5 || m_flags !== 4'b1100) begin
         fails++;
         $display("FAIL ignore_busy got lat=%0d flags=%b required lat=5 flags=1100", lat, m_flags);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      run(0, 64'h1, 64'h2, 3'd4, lat);
      tests++;
      if (lat !== 5 || m_flags !== 4'b1011) begin
         fails++;
         $display("FAIL b2b_first got lat=%0d flags=%b required lat=5 flags=1011", lat, m_flags);
      end
      a_v = 64'd5; b_v = 64'd5; op_v = 3'd6; start_v = 1'b1;
      @(posedge clk); lat = 1;
      @(negedge clk); start_v = 1'b0;
      tests++;
      if (m_busy !== 1'b1 || m_done !== 1'b0) begin
         fails++;
         $display("FAIL b2b_bubble got busy=%b done=%b required busy=1 done=0", m_busy, m_done);
      end
      wait_done(lat);
      tests++;
      if (lat !== 5 || m_flags !== 4'b1100) begin
         fails++;
         $display("FAIL b2b_le got lat=%0d flags=%b required lat=5 flags=1100", lat, m_flags);
      end
   endtask

   task automatic test_reset_mid_scan();
      int lat;
      int seen = 0;
      @(negedge clk);
      cur = 0; a_v = 64'hCAFE0000; b_v = 64'hCAFE0000; op_v = 3'd6; start_v = 1'b1;
      @(posedge clk);
      @(negedge clk); start_v = 1'b0;
      @(posedge clk);
      @(negedge clk); rst_n = 1'b0;
      #1;
      tests++;
      if ({m_busy, m_done, m_flags} !== 6'b0) begin
         fails++;
         $display("FAIL mid_reset got %b required 000000", {m_busy, m_done, m_flags});
      end
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (m_done) seen++;
      end
      tests++;
      if (seen !== 0) begin
         fails++;
         $display("FAIL mid_reset_nodone got %0d done pulses required 0", seen);
      end
      run(0, 64'h80000000, 64'h1, 3'd2, lat);
      tests++;
      if (lat !== 2 || m_flags !== 4'b1010) begin
         fails++;
         $display("FAIL mid_reset_recover got lat=%0d flags=%b required lat=2 flags=1010", lat, m_flags);
      end
   endtask

   task automatic test_sweep_params();
      int lat;
      run(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 3'd2, lat);
      tests++;
      if (lat !== 2 || m_flags !== 4'b1010) begin
         fails++;
         $display("FAIL w64_lt got lat=%0d flags=%b required lat=2 flags=1010", lat, m_flags);
      end
      run(2, 64'hFFFF_FFFF, 64'h0, 3'd2, lat);
      tests++;
      if (lat !== 2 || m_flags !== 4'b1010) begin
         fails++;
         $display("FAIL c32_lt got lat=%0d flags=%b required lat=2 flags=1010", lat, m_flags);
      end
      run(2, 64'h1234, 64'h1234, 3'd0, lat);
      tests++;
      if (lat !== 2 || m_flags !== 4'b1100) begin
         fails++;
         $display("FAIL c32_eq got lat=%0d flags=%b required lat=2 flags=1100", lat, m_flags);
      end
   endtask

   function automatic logic [3:0] ref_flags(input logic [63:0] a, input logic [63:0] b,
                                            input int w, input logic [2:0] op);
      logic e, ls, lu, r;
      e  = (a == b);
      lu = (a < b);
      ls = (a[w-1] != b[w-1]) ? a[w-1] : lu;
      case (op)
         3'd0: r = e;       3'd1: r = !e;
         3'd2: r = ls;      3'd3: r = !ls;
         3'd4: r = lu;      3'd5: r = !lu;
         3'd6: r = ls | e;  default: r = !(ls | e);
      endcase
      return {r, e, ls, lu};
   endfunction

   function automatic int ref_lat(input logic [63:0] a, input logic [63:0] b, input int n, input int c);
      logic [63:0] x = a ^ b;
      logic [63:0] m = (64'd1 << c) - 64'd1;
      for (int s = 0; s < n; s++)
         if (((x >> ((n - 1 - s) * c)) & m) != 64'd0) return s + 2;
      return n + 1;
   endfunction

   task automatic test_random();
      int lat, w, c, exp_lat;
      logic [63:0] ra, rb;
      logic [2:0]  rop;
      logic [3:0]  exp_f;
      for (int inst = 0; inst < 3; inst++) begin
         w = (inst == 1) ? 64 : 32;
         c = (inst == 0) ? 8 : ((inst == 1) ? 16 : 32);
         for (int k = 0; k < 12; k++) begin
            ra = {$urandom, $urandom};
            case (k % 3)
               0: rb = {$urandom, $urandom};
               1: rb = ra ^ (64'd1 << $urandom_range(0, w - 1));
               default: rb = ra;
            endcase
            if (w == 32) begin ra[63:32] = '0; rb[63:32] = '0; end
            rop     = 3'($urandom_range(0, 7));
            exp_f   = ref_flags(ra, rb, w, rop);
            exp_lat = ref_lat(ra, rb, w / c, c);
            run(inst, ra, rb, rop, lat);
            tests++;
            if (lat !== exp_lat || m_flags !== exp_f) begin
               fails++;
               $display("FAIL rand inst=%0d a=%h b=%h op=%0d got lat=%0d flags=%b required lat=%0d flags=%b",
                        inst, ra, rb, rop, lat, m_flags, exp_lat, exp_f);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_equal();
      test_msb_signed();
      test_low_chunk();
      test_ignore_busy();
      test_back_to_back();
      test_reset_mid_scan();
      test_sweep_params();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/seq_chunk_cmp.md
Name: seq_chunk_cmp

Overview:
- Parametrised, multi-cycle successor to the combinational branch comparator.
- Compares two WIDTH-bit operands CHUNK bits per cycle, scanning from the MSB chunk downward, and terminates at the first chunk that differs.
- Supports eight compare modes, signed and unsigned.
- Used in the execute stage for wide or slow compares; the stall logic holds the pipeline while busy=1.

Parameters:
- WIDTH, 32, operand width; must be a multiple of CHUNK.
- CHUNK, 8, bits compared per cycle; CHUNK==WIDTH is legal (single scan cycle).
- NCHUNK, WIDTH/CHUNK, derived localparam, not overridable.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- op  input  3  mode: 0 EQ, 1 NE, 2 LT, 3 GE, 4 LTU, 5 GEU, 6 LE, 7 GT. LT/GE/LE/GT are signed.
- a  input  WIDTH  operand A; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- busy  output  1  high while scanning.
- done  output  1  one-cycle pulse; result and flags are valid from this cycle.
- result  output  1  boolean outcome of op.
- eq  output  1  A==B.
- lt_s  output  1  A<B signed.
- lt_u  output  1  A<B unsigned.

Behaviour:
- Reset (reset=0, async): state=IDLE; busy, done, result, eq, lt_s, lt_u all 0; latched operands cleared.
- FSM states: IDLE, SCAN, DONE.
- IDLE or DONE with start=1: latch a, b, op; idx=NCHUNK-1; go to SCAN. busy=1 from the next cycle.
- start while busy=1 is ignored. Latched operands do not change mid-scan.
- SCAN, each cycle, comparing chunk ca=A[idx*CHUNK +: CHUNK] against cb:
  - ca!=cb: register eq=0 and lt_u=(ca<cb) unsigned.
  - lt_s: if idx==NCHUNK-1, signed chunk compare (MSB of chunk is the sign); else lt_s=lt_u.
  - Then go to DONE.
  - ca==cb and idx==0: register eq=1, lt_s=0, lt_u=0; go to DONE.
  - Otherwise idx=idx-1 and stay in SCAN.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE unless start is accepted.
- Back-to-back: a start accepted in DONE goes straight to SCAN with no idle bubble.
- result is registered together with the flags:
  - EQ=eq; NE=!eq.
  - LT=lt_s; GE=!lt_s.
  - LTU=lt_u; GEU=!lt_u.
  - LE=lt_s|eq; GT=!(lt_s|eq).
- result, eq, lt_s and lt_u hold their values until the next completion or reset.
- Latency counts rising edges from the start-accept edge to the first cycle with done=1:
  - first differing chunk at scan step s (s=0 is the MSB chunk) gives s+2;
  - equal operands give NCHUNK+1;
  - minimum is 2 (MSB chunk differs, or NCHUNK==1).
- Reset asserted mid-SCAN aborts the scan: outputs return to reset values and no done pulse is produced.
- Sign handling applies only to the MSB chunk. Lower chunks are always compared unsigned.

Test Plan:
- Equal operands, default params: a=b=0x12345678, op=EQ, start 1 cycle -> busy=1 for 4 cycles; done on the 5th edge after accept; result=1, eq=1, lt_s=0, lt_u=0.
- MSB chunk differs, signed vs unsigned: a=0x80000000, b=0x00000001.
  - op=LT -> done at edge 2, result=1, lt_s=1, lt_u=0.
  - Repeat with op=GEU -> result=1.
- Low chunk differs: a=0x000000FF, b=0x00000100, op=LTU -> chunk 1 differs (s=2); done at edge 4; lt_u=1, lt_s=1, eq=0, result=1.
  - Repeat with op=GT -> result=0.
- Handshake: pulse start again while busy with a different a/b -> ignored; first result unchanged.
  - Assert start in the DONE cycle with a=5, b=5, op=LE -> accepted with no IDLE cycle; result=1.
- Reset mid-scan: assert reset=0 two cycles into an equal-operand scan -> busy, done, result and all flags 0 immediately; no done pulse after release; next start completes normally.
- Parameter sweep: WIDTH=64, CHUNK=16; and WIDTH=32, CHUNK=32.
  - a=-1, b=0, op=LT -> result=1.
  - CHUNK=32 -> done at edge 2.
  - Random a/b/op compared against a reference model across all 8 ops.
